// File: rtl/maxpool_stream_engine_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_stream_engine_pkg
//   Shared constants for the streaming max-pool engine.
//   - FSM state encodings (IDLE, STREAM, SCAN, EMIT, DONE)
//   - clog2_min1(): ceiling log2 clamped to a minimum of one bit, used to
//     size counters and address fields from the map/window parameters.
// ---------------------------------------------------------------------------
package maxpool_stream_engine_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STREAM = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits = bits + 1;
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/maxpool_stream_engine_pool_window_max.sv
// ---------------------------------------------------------------------------
// pool_window_max
//   Sequential running-maximum accumulator for one pooling window.
//   Ports:
//     clk, rst  clock / asynchronous active-high reset
//     clear     load din unconditionally (first element of a window)
//     en        compare din against the running max and keep the larger
//     din       signed candidate value
//     max_out   registered running maximum
//   Ties keep the value already held, so the earliest maximum wins.
// ---------------------------------------------------------------------------
module pool_window_max
  import maxpool_stream_engine_pkg::*;
#(
  parameter int DATA_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] max_out
);

  logic signed [DATA_W-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= din;
    end else if (en && (din > acc)) begin
      acc <= din;
    end
  end

  assign max_out = acc;

endmodule

// File: rtl/maxpool_stream_engine.sv
// ---------------------------------------------------------------------------
// maxpool_stream_engine
//   Streaming K x K / stride-S max-pool stage. Accepts raster-order conv
//   results over a valid/ready handshake, keeps the last POOL_K rows in a
//   ring buffer, and for every complete window scans the K*K buffered
//   values through pool_window_max, then strobes the maximum out.
//   Ports:
//     clk, rst    clock / asynchronous active-high reset
//     start       begin a frame (only honoured in IDLE)
//     in_valid    in_data valid
//     in_data     signed conv result
//     in_ready    engine accepts in_data (STREAM state only)
//     out_valid   one-cycle write strobe
//     out_addr    row-major pooled index (held between strobes)
//     out_data    signed window maximum (held between strobes)
//     busy        high outside IDLE
//     done        one-cycle pulse after the final output
//   Configuration macro:
//     RELU_EN     when defined, inputs are clamped to max(0, in_data)
//                 before they are written to the ring buffer.
// ---------------------------------------------------------------------------
module maxpool_stream_engine
  import maxpool_stream_engine_pkg::*;
#(
  parameter int DATA_W  = 23,
  parameter int IN_W    = 7,
  parameter int IN_H    = 7,
  parameter int POOL_K  = 3,
  parameter int POOL_S  = 2,
  localparam int OUT_W  = (IN_W - POOL_K) / POOL_S + 1,
  localparam int OUT_H  = (IN_H - POOL_K) / POOL_S + 1,
  localparam int OA_W   = clog2_min1(OUT_W * OUT_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OA_W-1:0]          out_addr,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     done
);

  // Column index, trigger-column (may run past the map edge), row and
  // trigger-row widths, ring-buffer slot width.
  localparam int CIW = clog2_min1(IN_W);
  localparam int CW  = clog2_min1(IN_W + POOL_S);
  localparam int RW  = clog2_min1(IN_H + POOL_S);
  localparam int KW  = clog2_min1(POOL_K);
  localparam int KW1 = KW + 1;
  localparam int KD  = 1 << KW;
  localparam int CD  = 1 << CIW;

  logic [2:0]               state;
  logic [CIW-1:0]           col, scan_col0, rd_col;
  logic [CW-1:0]            trig_col;
  logic [RW-1:0]            row, trig_row;
  logic [KW-1:0]            row_slot, next_slot, scan_row0, scan_r, scan_c, rd_slot;
  logic [KW1-1:0]           slot_sum;
  logic [OA_W-1:0]          out_cnt, out_addr_q;
  logic signed [DATA_W-1:0] out_data_q, wr_data, rd_data, win_max;
  logic                     hs, last_col, trigger, scan_first, scan_last;
  logic                     acc_clear, acc_en;

  // Power-of-two sized so every index is exactly as wide as the array needs.
  logic signed [DATA_W-1:0] buf_mem [KD][CD];

`ifdef RELU_EN
  assign wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign wr_data = in_data;
`endif

  assign in_ready  = (state == ST_STREAM);
  assign hs        = in_valid & in_ready;
  assign last_col  = (col == CIW'(IN_W - 1));
  assign next_slot = (row_slot == KW'(POOL_K - 1)) ? '0 : row_slot + KW'(1);

  // trig_row/trig_col step by the stride from K-1, so a match means the
  // element closes a complete, stride-aligned window.
  assign trigger   = hs && (row == trig_row) && (CW'(col) == trig_col);

  assign scan_first = (scan_r == '0) && (scan_c == '0);
  assign scan_last  = (scan_r == KW'(POOL_K - 1)) && (scan_c == KW'(POOL_K - 1));

  // The oldest window row lives in the slot after the trigger row's slot.
  assign slot_sum = KW1'(scan_row0) + KW1'(scan_r);
  assign rd_slot  = (slot_sum >= KW1'(POOL_K)) ? KW'(slot_sum - KW1'(POOL_K)) : KW'(slot_sum);
  assign rd_col   = scan_col0 + CIW'(scan_c);
  assign rd_data  = buf_mem[rd_slot][rd_col];

  assign acc_en    = (state == ST_SCAN);
  assign acc_clear = acc_en && scan_first;

  pool_window_max #(
    .DATA_W (DATA_W)
  ) u_window_max (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc_clear),
    .en      (acc_en),
    .din     (rd_data),
    .max_out (win_max)
  );

  // Buffer contents survive reset; only the handshake writes them.
  always_ff @(posedge clk) begin
    if (hs) begin
      buf_mem[row_slot][col] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      row_slot   <= '0;
      trig_col   <= '0;
      trig_row   <= '0;
      scan_col0  <= '0;
      scan_row0  <= '0;
      scan_r     <= '0;
      scan_c     <= '0;
      out_cnt    <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_STREAM;
            col      <= '0;
            row      <= '0;
            row_slot <= '0;
            trig_col <= CW'(POOL_K - 1);
            trig_row <= RW'(POOL_K - 1);
            out_cnt  <= '0;
          end
        end
        ST_STREAM: begin
          if (hs) begin
            if (last_col) begin
              col      <= '0;
              row      <= row + RW'(1);
              row_slot <= next_slot;
              trig_col <= CW'(POOL_K - 1);
              if (row == trig_row) begin
                trig_row <= trig_row + RW'(POOL_S);
              end
            end else begin
              col <= col + CIW'(1);
              if (CW'(col) == trig_col) begin
                trig_col <= trig_col + CW'(POOL_S);
              end
            end
            if (trigger) begin
              state     <= ST_SCAN;
              scan_row0 <= next_slot;
              scan_col0 <= col - CIW'(POOL_K - 1);
              scan_r    <= '0;
              scan_c    <= '0;
            end
          end
        end
        ST_SCAN: begin
          if (scan_c == KW'(POOL_K - 1)) begin
            scan_c <= '0;
            scan_r <= scan_r + KW'(1);
          end else begin
            scan_c <= scan_c + KW'(1);
          end
          if (scan_last) begin
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          out_addr_q <= out_cnt;
          out_data_q <= win_max;
          out_cnt    <= out_cnt + OA_W'(1);
          state      <= (out_cnt == OA_W'(OUT_W * OUT_H - 1)) ? ST_DONE : ST_STREAM;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // During the strobe cycle the fresh result is shown directly; the held
  // copies keep the outputs stable until the next strobe.
  assign out_valid = (state == ST_EMIT);
  assign out_addr  = out_valid ? out_cnt : out_addr_q;
  assign out_data  = out_valid ? win_max : out_data_q;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule
